// File: rtl/univ_shiftreg_pkg.sv
// Shared definitions for the universal shift register: mode encodings.
// The optional rotate feature is selected by UNIV_SHIFTREG_ROTATE_EN.
package univ_shiftreg_pkg;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

endpackage : univ_shiftreg_pkg

// File: rtl/univ_shiftreg_bitcnt.sv
// Shift counter for the universal shift register: counts shift edges modulo
// WIDTH and raises a one-cycle frame_valid pulse when a frame of WIDTH shifts completes.
module shift_bitcnt #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     res,
    input  logic                     shift_evt,
    input  logic                     clr,
    output logic [$clog2(WIDTH)-1:0] bit_cnt,
    output logic                     frame_valid
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] cnt_d;
    logic          fv_d;

    // Next count: load clears, a shift advances/wraps, anything else holds.
    always_comb begin
        cnt_d = bit_cnt;
        fv_d  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (shift_evt) begin
            if (bit_cnt == LAST) begin
                cnt_d = '0;
                fv_d  = 1'b1;
            end else begin
                cnt_d = bit_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            bit_cnt     <= '0;
            frame_valid <= 1'b0;
        end else begin
            bit_cnt     <= cnt_d;
            frame_valid <= fv_d;
        end
    end

endmodule : shift_bitcnt

// File: rtl/univ_shiftreg.sv
// Universal shift register: hold / shift right / shift left / parallel load.
// Define UNIV_SHIFTREG_ROTATE_EN to let rot=1 recirculate the shifted-out bit.
module univ_shiftreg
    import univ_shiftreg_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     res,
    input  logic                     en,
    input  logic [1:0]               mode,
    input  logic                     rot,
    input  logic                     sin_msb,
    input  logic                     sin_lsb,
    input  logic [WIDTH-1:0]         pin,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(WIDTH)-1:0] bit_cnt,
    output logic                     frame_valid
);

    mode_e            mode_c;
    logic             fill_r_c;
    logic             fill_l_c;
    logic             shift_evt_c;
    logic             clr_c;
    logic [WIDTH-1:0] dout_d;

    assign mode_c = mode_e'(mode);

    // Fill bit selection: serial inputs, or the bit falling off the far end when rotating.
    always_comb begin
        fill_r_c = sin_msb;
        fill_l_c = sin_lsb;
`ifdef UNIV_SHIFTREG_ROTATE_EN
        if (rot) begin
            fill_r_c = dout[0];
            fill_l_c = dout[WIDTH-1];
        end
`endif
    end

`ifndef UNIV_SHIFTREG_ROTATE_EN
    logic unused_rot;
    assign unused_rot = rot;
`endif

    always_comb begin
        dout_d      = dout;
        shift_evt_c = 1'b0;
        clr_c       = 1'b0;
        if (en) begin
            case (mode_c)
                MODE_SHR: begin
                    dout_d      = {fill_r_c, dout[WIDTH-1:1]};
                    shift_evt_c = 1'b1;
                end
                MODE_SHL: begin
                    dout_d      = {dout[WIDTH-2:0], fill_l_c};
                    shift_evt_c = 1'b1;
                end
                MODE_LOAD: begin
                    dout_d = pin;
                    clr_c  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            dout <= '0;
        end else begin
            dout <= dout_d;
        end
    end

    shift_bitcnt #(
        .WIDTH(WIDTH)
    ) u_bitcnt (
        .clk        (clk),
        .res        (res),
        .shift_evt  (shift_evt_c),
        .clr        (clr_c),
        .bit_cnt    (bit_cnt),
        .frame_valid(frame_valid)
    );

endmodule : univ_shiftreg

// File: tb/tb_univ_shiftreg.sv
// Directed, table-driven bench for univ_shiftreg at WIDTH=4, plus hand-written
// sequences for async reset, reset release and back-to-back frames.
module tb_univ_shiftreg;

    localparam int unsigned WIDTH = 4;
`ifdef UNIV_SHIFTREG_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    localparam logic [1:0] M_HOLD = 2'b00;
    localparam logic [1:0] M_SHR  = 2'b01;
    localparam logic [1:0] M_SHL  = 2'b10;
    localparam logic [1:0] M_LOAD = 2'b11;

    logic             clk;
    logic             res;
    logic             en;
    logic [1:0]       mode;
    logic             rot;
    logic             sin_msb;
    logic             sin_lsb;
    logic [WIDTH-1:0] pin;
    logic [WIDTH-1:0] dout;
    logic [1:0]       bit_cnt;
    logic             frame_valid;

    int n_cmp  = 0;
    int n_fail = 0;

    univ_shiftreg #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .res        (res),
        .en         (en),
        .mode       (mode),
        .rot        (rot),
        .sin_msb    (sin_msb),
        .sin_lsb    (sin_lsb),
        .pin        (pin),
        .dout       (dout),
        .bit_cnt    (bit_cnt),
        .frame_valid(frame_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic       rot;
        logic       msb;
        logic       lsb;
        logic [3:0] pin;
        logic [3:0] e_dout;
        logic [1:0] e_cnt;
        logic       e_fv;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic e, input logic [1:0] m, input logic r,
                                input logic ms, input logic ls, input logic [3:0] p,
                                input logic [3:0] ed, input logic [1:0] ec, input logic ef);
        vec_t v;
        v.en = e; v.mode = m; v.rot = r; v.msb = ms; v.lsb = ls; v.pin = p;
        v.e_dout = ed; v.e_cnt = ec; v.e_fv = ef;
        return v;
    endfunction

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic e, input logic [1:0] m, input logic r,
                         input logic ms, input logic ls, input logic [3:0] p);
        en = e; mode = m; rot = r; sin_msb = ms; sin_lsb = ls; pin = p;
    endtask

    task automatic step(input logic e, input logic [1:0] m, input logic ms,
                        input logic ls, input logic [3:0] p);
        @(negedge clk);
        drive(e, m, 1'b0, ms, ls, p);
        @(posedge clk);
        #1;
    endtask

    initial begin
        res = 1'b0;
        drive(1'b1, M_SHR, 1'b0, 1'b1, 1'b1, 4'h0);
        #1;
        chk("reset_dout", dout, 0);
        chk("reset_cnt", bit_cnt, 0);
        chk("reset_fv", frame_valid, 0);
        // Clock edges with a shift selected must not disturb reset state.
        @(posedge clk); #1;
        chk("reset_clk_dout", dout, 0);
        chk("reset_clk_cnt", bit_cnt, 0);
        @(negedge clk);
        res = 1'b1;

        tbl.push_back(mk(1, M_LOAD, 0, 0, 0, 4'b1001, 4'b1001, 0, 0));
        tbl.push_back(mk(1, M_SHL,  0, 0, 0, 4'h0,    4'b0010, 1, 0));
        tbl.push_back(mk(1, M_LOAD, 0, 0, 0, 4'b0000, 4'b0000, 0, 0));
        tbl.push_back(mk(1, M_SHR,  0, 1, 0, 4'h0,    4'b1000, 1, 0));
        tbl.push_back(mk(1, M_SHR,  0, 0, 0, 4'h0,    4'b0100, 2, 0));
        tbl.push_back(mk(1, M_SHR,  0, 1, 0, 4'h0,    4'b1010, 3, 0));
        tbl.push_back(mk(1, M_SHR,  0, 1, 0, 4'h0,    4'b1101, 0, 1));
        tbl.push_back(mk(1, M_HOLD, 0, 1, 1, 4'hF,    4'b1101, 0, 0));
        tbl.push_back(mk(1, M_SHL,  0, 0, 1, 4'h0,    4'b1011, 1, 0));
        tbl.push_back(mk(1, M_SHR,  0, 0, 0, 4'h0,    4'b0101, 2, 0));
        tbl.push_back(mk(0, M_SHL,  0, 1, 1, 4'h0,    4'b0101, 2, 0));
        tbl.push_back(mk(0, M_LOAD, 0, 1, 1, 4'hF,    4'b0101, 2, 0));
        tbl.push_back(mk(0, M_SHR,  0, 1, 1, 4'h0,    4'b0101, 2, 0));
        tbl.push_back(mk(1, M_SHR,  0, 1, 0, 4'h0,    4'b1010, 3, 0));
        tbl.push_back(mk(1, M_SHL,  0, 0, 0, 4'h0,    4'b0100, 0, 1));
        tbl.push_back(mk(1, M_HOLD, 0, 0, 0, 4'h0,    4'b0100, 0, 0));
        tbl.push_back(mk(1, M_LOAD, 1, 0, 0, 4'b1000, 4'b1000, 0, 0));
        tbl.push_back(mk(1, M_SHL,  1, 0, 0, 4'h0, ROT ? 4'b0001 : 4'b0000, 1, 0));
        tbl.push_back(mk(1, M_SHL,  1, 0, 0, 4'h0, ROT ? 4'b0010 : 4'b0000, 2, 0));
        tbl.push_back(mk(1, M_SHL,  1, 0, 0, 4'h0, ROT ? 4'b0100 : 4'b0000, 3, 0));
        tbl.push_back(mk(1, M_SHL,  1, 0, 0, 4'h0, ROT ? 4'b1000 : 4'b0000, 0, 1));
        tbl.push_back(mk(1, M_LOAD, 0, 0, 0, 4'b0011, 4'b0011, 0, 0));
        tbl.push_back(mk(1, M_SHR,  1, 0, 0, 4'h0, ROT ? 4'b1001 : 4'b0001, 1, 0));

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].en, tbl[i].mode, tbl[i].rot, tbl[i].msb, tbl[i].lsb, tbl[i].pin);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_dout", i), dout, tbl[i].e_dout);
            chk($sformatf("v%0d_cnt", i), bit_cnt, tbl[i].e_cnt);
            chk($sformatf("v%0d_fv", i), frame_valid, tbl[i].e_fv);
        end

        // Async reset mid-frame with dout=1011 clears everything without an edge.
        step(1, M_LOAD, 0, 0, 4'b0101);
        step(1, M_SHL, 0, 1, 4'h0);
        chk("pre_rst_dout", dout, 4'b1011);
        chk("pre_rst_cnt", bit_cnt, 1);
        @(negedge clk);
        drive(1'b1, M_SHL, 1'b0, 1'b0, 1'b1, 4'h0);
        res = 1'b0;
        #1;
        chk("async_rst_dout", dout, 0);
        chk("async_rst_cnt", bit_cnt, 0);
        chk("async_rst_fv", frame_valid, 0);
        // First edge after release performs the selected shift from a fresh count.
        @(negedge clk);
        res = 1'b1;
        @(posedge clk); #1;
        chk("rel_dout", dout, 4'b0001);
        chk("rel_cnt", bit_cnt, 1);
        chk("rel_fv", frame_valid, 0);

        // Eight continuous shifts: pulses after shifts 4 and 8 only.
        begin
            int pulses = 0;
            int first_at = -1;
            int last_at = -1;
            step(1, M_LOAD, 0, 0, 4'h0);
            for (int k = 0; k < 8; k++) begin
                step(1, M_SHR, 1, 0, 4'h0);
                chk($sformatf("b2b_fv%0d", k), frame_valid, (k % 4 == 3) ? 1 : 0);
                if (frame_valid) begin
                    pulses++;
                    if (first_at < 0) first_at = k;
                    last_at = k;
                end
            end
            chk("b2b_pulses", pulses, 2);
            chk("b2b_gap", last_at - first_at, 4);
            chk("b2b_dout", dout, 4'b1111);
            chk("b2b_cnt", bit_cnt, 0);
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_univ_shiftreg
